// File: rtl/load_store_pkg.sv
// Shared types and default sizing for the load/store reservoir scheduler.
package load_store_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } sched_state_t;

    typedef enum logic {
        OWN_LOAD,
        OWN_STORE
    } owner_t;

    localparam int unsigned N_DEF     = 12500;
    localparam int unsigned BURST_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the loader, bit 1 the storer.
// On a tie the side that did not own the reservoir last is granted.
module rr_arb2
    import load_store_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    owner_t last_owner_q;

    // One-hot grant from the current requests and the last owner
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_owner_q == OWN_STORE) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember who was granted whenever a grant is actually taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner_q <= OWN_STORE;
        end else if (advance) begin
            if (gnt[0]) begin
                last_owner_q <= OWN_LOAD;
            end else if (gnt[1]) begin
                last_owner_q <= OWN_STORE;
            end
        end
    end

endmodule

// File: rtl/load_store_sched.sv
// Scheduler for a shared load/store reservoir. Owns the level counter,
// grants bounded bursts to the loader or storer and reports full/empty.
module load_store_sched
    import load_store_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned CBITS = 14,
    parameter int unsigned BURST = BURST_DEF,
    parameter int unsigned BBITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_req,
    input  logic             st_req,
    output logic             ld_gnt,
    output logic             st_gnt,
    output logic [CBITS-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam logic [CBITS-1:0] LvlMax   = CBITS'(N);
    localparam logic [BBITS-1:0] BurstMax = BBITS'(BURST);

    sched_state_t     state_q, state_d;
    logic [CBITS-1:0] level_d;
    logic [BBITS-1:0] bcnt_q, bcnt_d;
    logic [1:0]       elig;
    logic [1:0]       arb_gnt;
    logic             advance;

    assign elig    = {st_req && !empty, ld_req && !full};
    assign advance = (state_q == IDLE) && (elig != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (advance),
        .gnt     (arb_gnt)
    );

    // Next state, level and burst count; exits are judged on post-transfer values
    always_comb begin
        state_d = state_q;
        level_d = level;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt[0]) begin
                    state_d = LOAD;
                    bcnt_d  = '0;
                end else if (arb_gnt[1]) begin
                    state_d = STORE;
                    bcnt_d  = '0;
                end
            end
            LOAD: begin
                if (!ld_req) begin
                    state_d = IDLE;
                end else begin
                    level_d = level + CBITS'(1);
                    bcnt_d  = bcnt_q + BBITS'(1);
                    if ((level_d == LvlMax) || (bcnt_d == BurstMax)) begin
                        state_d = IDLE;
                    end
                end
            end
            STORE: begin
                if (!st_req) begin
                    state_d = IDLE;
                end else begin
                    level_d = level - CBITS'(1);
                    bcnt_d  = bcnt_q + BBITS'(1);
                    if ((level_d == '0) || (bcnt_d == BurstMax)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register state and all outputs; full/empty follow the next level
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            level   <= '0;
            bcnt_q  <= '0;
            ld_gnt  <= 1'b0;
            st_gnt  <= 1'b0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            state_q <= state_d;
            level   <= level_d;
            bcnt_q  <= bcnt_d;
            ld_gnt  <= (state_d == LOAD);
            st_gnt  <= (state_d == STORE);
            full    <= (level_d == LvlMax);
            empty   <= (level_d == '0);
        end
    end

    a_gnt_excl: assert property (@(posedge clk) disable iff (!rst) !(ld_gnt && st_gnt));
    a_lvl_max:  assert property (@(posedge clk) disable iff (!rst) level <= LvlMax);
    a_ld_room:  assert property (@(posedge clk) disable iff (!rst) ld_gnt |-> (level < LvlMax));
    a_st_avail: assert property (@(posedge clk) disable iff (!rst) st_gnt |-> (level > '0));
    a_ld_lat:   assert property (@(posedge clk) disable iff (!rst)
                    (ld_req && !full && (state_q == IDLE) && !st_req) |=> ld_gnt);

endmodule

// File: tb/tb_load_store_sched.sv
// Directed table-driven bench for load_store_sched (N=5, BURST=3), plus a
// random run on a default-sized instance against a transfer-rule level model.
module tb_load_store_sched;

    logic        clk;
    logic        rst, ld_req, st_req;
    logic        ld_gnt, st_gnt, full, empty;
    logic [13:0] level;

    logic        rst2, ld_req2, st_req2;
    logic        ld_gnt2, st_gnt2, full2, empty2;
    logic [13:0] level2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        st;
        logic        lg;
        logic        sg;
        int unsigned lvl;
        logic        f;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    load_store_sched #(.N(5), .CBITS(14), .BURST(3), .BBITS(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .ld_req (ld_req),
        .st_req (st_req),
        .ld_gnt (ld_gnt),
        .st_gnt (st_gnt),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    load_store_sched #(.N(12500), .CBITS(14), .BURST(4), .BBITS(3)) dut2 (
        .clk    (clk),
        .rst    (rst2),
        .ld_req (ld_req2),
        .st_req (st_req2),
        .ld_gnt (ld_gnt2),
        .st_gnt (st_gnt2),
        .level  (level2),
        .full   (full2),
        .empty  (empty2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic l, input logic s, input logic lg,
                       input logic sg, input int unsigned lvl, input logic f, input logic e);
        vec_t v;
        v.rst = r; v.ld = l; v.st = s; v.lg = lg; v.sg = sg; v.lvl = lvl; v.f = f; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic lg, input logic sg,
                           input int unsigned lvl, input logic f, input logic e);
        chk({tag, "_ld_gnt"}, ld_gnt, lg);
        chk({tag, "_st_gnt"}, st_gnt, sg);
        chk({tag, "_level"}, level, lvl);
        chk({tag, "_full"}, full, f);
        chk({tag, "_empty"}, empty, e);
    endtask

    int unsigned exp_lvl;
    int          waited;
    logic        l_xfer, s_xfer;

    initial begin
        rst = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        rst2 = 1'b0; ld_req2 = 1'b0; st_req2 = 1'b0;

        //   rst ld st | lg sg lvl full empty
        add(0, 0, 0,   0, 0, 0, 0, 1);  // reset
        add(1, 1, 0,   1, 0, 0, 0, 1);  // grant, no transfer yet
        add(1, 1, 0,   1, 0, 1, 0, 0);
        add(1, 1, 0,   1, 0, 2, 0, 0);
        add(1, 1, 0,   0, 0, 3, 0, 0);  // burst limit
        add(1, 1, 0,   1, 0, 3, 0, 0);  // after one idle cycle
        add(1, 1, 0,   1, 0, 4, 0, 0);
        add(1, 1, 0,   0, 0, 5, 1, 0);  // full
        add(1, 1, 0,   0, 0, 5, 1, 0);  // no grant while full
        add(1, 1, 0,   0, 0, 5, 1, 0);
        add(1, 0, 1,   0, 1, 5, 1, 0);  // store granted
        add(1, 0, 1,   0, 1, 4, 0, 0);
        add(1, 0, 1,   0, 1, 3, 0, 0);
        add(1, 0, 1,   0, 0, 2, 0, 0);  // burst limit, last owner store
        add(1, 1, 1,   1, 0, 2, 0, 0);  // tie -> load
        add(1, 1, 1,   1, 0, 3, 0, 0);
        add(1, 1, 1,   1, 0, 4, 0, 0);
        add(1, 1, 1,   0, 0, 5, 1, 0);
        add(1, 1, 1,   0, 1, 5, 1, 0);  // only store eligible
        add(1, 1, 1,   0, 1, 4, 0, 0);
        add(1, 1, 1,   0, 1, 3, 0, 0);
        add(1, 1, 1,   0, 0, 2, 0, 0);
        add(1, 1, 1,   1, 0, 2, 0, 0);  // tie -> load again
        add(1, 1, 1,   1, 0, 3, 0, 0);
        add(1, 0, 1,   0, 0, 3, 0, 0);  // loader drops mid-burst
        add(1, 0, 1,   0, 1, 3, 0, 0);  // store after turnaround
        add(1, 0, 1,   0, 1, 2, 0, 0);
        add(0, 0, 1,   0, 0, 0, 0, 1);  // reset mid-store
        add(1, 0, 1,   0, 0, 0, 0, 1);  // store at empty: no grant
        add(1, 0, 1,   0, 0, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 0, 1);  // one-cycle load pulse
        add(1, 0, 0,   0, 0, 0, 0, 1);  // released, no transfer
        add(1, 0, 0,   0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ld_req = vecs[i].ld; st_req = vecs[i].st;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].lg, vecs[i].sg, vecs[i].lvl,
                    vecs[i].f, vecs[i].e);
        end

        // Reset in the middle of a load burst with level 3
        rst = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        step();
        rst = 1'b1; ld_req = 1'b1;
        waited = 0;
        step();
        while (!(ld_gnt && level == 14'd3) && waited < 20) begin
            step();
            waited++;
        end
        chk("midload_reached", (ld_gnt && level == 14'd3) ? 1 : 0, 1);
        rst = 1'b0;
        step();
        chk_all("midload_rst", 0, 0, 0, 0, 1);
        rst = 1'b1;
        step();
        chk_all("midload_regrant", 1, 0, 0, 0, 1);
        ld_req = 1'b0;
        step();

        // Random run on the full-size instance against a level model
        step();
        rst2 = 1'b1;
        exp_lvl = 0;
        for (int c = 0; c < 10000; c++) begin
            ld_req2 = ($urandom_range(0, 99) < 55);
            st_req2 = ($urandom_range(0, 99) < 45);
            l_xfer = ld_req2 && ld_gnt2;
            s_xfer = st_req2 && st_gnt2;
            step();
            if (l_xfer) exp_lvl++;
            if (s_xfer) exp_lvl--;
            checks++;
            if (level2 != 14'(exp_lvl) || exp_lvl > 12500 ||
                full2 != (exp_lvl == 12500) || empty2 != (exp_lvl == 0) ||
                (ld_gnt2 && st_gnt2)) begin
                errors++;
                $display("FAIL rand_cyc%0d: level %0d full %0b empty %0b gnts %0b%0b expected level %0d",
                         c, level2, full2, empty2, ld_gnt2, st_gnt2, exp_lvl);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
